seq_addsub: RTL and testbench
=============================

// Module: seq_addsub
//
// PURPOSE
//   Parametrised multi-cycle adder/subtractor: WIDTH-bit add or subtract done
//   CHUNK bits per clock, ripple carry held in a register between chunks.
//   Successor to the fixed 4-bit combinational ripple adder. Trades latency for
//   area on wide datapaths (ALU, accumulators). Valid/ready on input and output.
//
// PARAMETERS
//   WIDTH  16  operand/result width in bits
//   CHUNK  4   bits added per cycle; WIDTH % CHUNK == 0 required (elab error otherwise)
//   NCHUNK = WIDTH/CHUNK (localparam), cycles per operation
//
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   in_valid   in   1      operands/mode valid
//   in_ready   out  1      block can accept an operation
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   sub        in   1      0: a+b, 1: a-b (a + ~b + 1)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   c_out      out  1      carry out of MSB; for sub, 1 = no borrow (a >= b unsigned)
//   overflow   out  1      signed overflow: carry into MSB XOR carry out of MSB
//
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, in_ready=0 during reset then 1,
//     out_valid=0, sum=0, c_out=0, overflow=0, chunk counter=0, carry reg=0.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. in_valid&&in_ready at edge: latch a, (sub ? ~b : b),
//     carry reg=sub, counter=0, go RUN. Inputs ignored outside IDLE.
//   RUN: in_ready=0. Each edge adds chunk[counter] of latched operands + carry
//     reg, writes that CHUNK slice of sum, updates carry reg, counter++.
//     On last chunk (counter==NCHUNK-1): set c_out, overflow, go DONE,
//     out_valid=1 from that edge. Latency: out_valid high NCHUNK edges after
//     acceptance edge (16/4 -> 4 cycles).
//   DONE: out_valid=1; sum/c_out/overflow stable until out_valid&&out_ready
//     edge, then out_valid=0, go IDLE. No new operand accepted in same cycle.
//   sum intermediate slices may change during RUN; only valid with out_valid.
//   CHUNK==WIDTH: NCHUNK=1, single RUN cycle.
//   Reset mid-RUN/DONE: operation aborted, no result produced, reset values.
//   Throughput: one op per NCHUNK+2 cycles with out_ready held high.
//
// TESTING (WIDTH=16, CHUNK=4 unless stated)
//   add 0x1234+0x0FFF -> sum=0x2233, c_out=0, overflow=0, out_valid 4 cycles
//     after accept.
//   add 0xFFFF+0x0001 -> sum=0x0000, c_out=1, overflow=0; 0x7FFF+0x0001 ->
//     sum=0x8000, c_out=0, overflow=1.
//   sub 0x0005-0x0007 -> sum=0xFFFE, c_out=0, overflow=0; sub 0x8000-0x0001 ->
//     sum=0x7FFF, c_out=1, overflow=1.
//   backpressure: out_ready low 3 cycles in DONE -> outputs stable, in_ready=0,
//     operands changed on a/b meanwhile have no effect; out_ready high -> IDLE.
//   rst_n low during 2nd RUN cycle -> out_valid stays 0, all outputs 0; next
//     op 0x0001+0x0001 -> 0x0002 normally.
//   CHUNK=16 config: 0xABCD+0x1111 -> sum=0xBCDE, out_valid 1 cycle after accept;
//     random 1000-op compare vs reference model for both configs.

Source files
------------

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock with a registered ripple carry
// Ports: clk, rst_n (async, active low); in_valid/in_ready + a, b, sub accept an operation;
//        out_valid/out_ready hand over sum, c_out (no-borrow for sub) and overflow (signed).
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (WIDTH % CHUNK != 0) begin : g_chk
    $error("seq_addsub: WIDTH must be a multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, c_out_q, ovf_q, out_valid_q;
  logic [CHUNK-1:0] a_ch, b_ch, slice_d;
  logic             carry_d, ovf_d, last;
  always_comb begin
    a_ch = a_q[cnt_q*CHUNK +: CHUNK];
    b_ch = b_q[cnt_q*CHUNK +: CHUNK];
    {carry_d, slice_d} = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK+1)'(carry_q);
    // carry into the MSB is recovered from the MSB sum bit and its operand bits
    ovf_d = carry_d ^ slice_d[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
    last = cnt_q == CW'(NCHUNK - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= sub ? ~b : b;
          carry_q <= sub;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          sum_q[cnt_q*CHUNK +: CHUNK] <= slice_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            c_out_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // reset forces IDLE, so in_ready must also be masked while rst_n is low
  assign in_ready  = rst_n && state_q == IDLE;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: checks seq_addsub in 16/4 and 16/16 configurations against an arithmetic model
module tb_seq_addsub;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_valid = '0, out_ready = '1, sub = '0;
  logic [1:0]  in_ready, out_valid, c_out, overflow;
  logic [15:0] a[2], b[2], sum[2];
  int          tests = 0, fails = 0;
  int          nlat[2] = '{4, 1};
  always #5 clk = ~clk;
  seq_addsub #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .sub(sub[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum[0]), .c_out(c_out[0]), .overflow(overflow[0]));
  seq_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .sub(sub[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum[1]), .c_out(c_out[1]), .overflow(overflow[1]));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // {overflow, c_out, sum} from plain signed/unsigned integer arithmetic
  function automatic logic [17:0] model(input logic [15:0] x, y, input logic s);
    int sr = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
    int ur = s ? int'(x) - int'(y) : int'(x) + int'(y);
    logic [15:0] r = 16'(ur);
    logic ov = sr > 32767 || sr < -32768;
    logic cy = s ? x >= y : ur > 65535;
    return {ov, cy, r};
  endfunction
  task automatic run_op(input int k, input logic [15:0] x, y, input logic s,
                        output logic [15:0] rs, output logic rc, ro, output int lat);
    int n = 0;
    a[k] = x; b[k] = y; sub[k] = s; in_valid[k] = 1'b1;
    while (!in_ready[k] && n < 20) begin tick(); n++; end
    tick();
    in_valid[k] = 1'b0; a[k] = 16'($urandom); b[k] = 16'($urandom); sub[k] = 1'($urandom);
    lat = 0;
    while (!out_valid[k] && lat < 50) begin tick(); lat++; end
    rs = sum[k]; rc = c_out[k]; ro = overflow[k];
  endtask
  task automatic consume(input int k);
    out_ready[k] = 1'b1;
    tick();
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({in_ready[k], out_valid[k], sum[k], c_out[k], overflow[k]} !== 20'h0) begin
        fails++;
        $display("FAIL reset_outputs cfg%0d: got rdy=%b vld=%b sum=%h c=%b ov=%b, want all 0",
                 k, in_ready[k], out_valid[k], sum[k], c_out[k], overflow[k]);
      end
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 2'b11) begin fails++; $display("FAIL reset_release_ready: got %b want 11", in_ready); end
    tick();
  endtask
  typedef struct {logic [15:0] x, y; logic s; logic [15:0] es; logic ec, eo;} vec_t;
  task automatic test_directed;
    vec_t v[5] = '{'{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0},
                   '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
                   '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
                   '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0},
                   '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1}};
    logic [15:0] rs; logic rc, ro; int lat;
    foreach (v[i]) begin
      run_op(0, v[i].x, v[i].y, v[i].s, rs, rc, ro, lat);
      tests++;
      if ({rs, rc, ro} !== {v[i].es, v[i].ec, v[i].eo} || lat !== 4) begin
        fails++;
        $display("FAIL directed_%0d: got sum=%h c=%b ov=%b lat=%0d, want sum=%h c=%b ov=%b lat=4",
                 i, rs, rc, ro, lat, v[i].es, v[i].ec, v[i].eo);
      end
      consume(0);
      tests++;
      if ({out_valid[0], in_ready[0]} !== 2'b01) begin
        fails++;
        $display("FAIL directed_handoff_%0d: got vld=%b rdy=%b want 0 1", i, out_valid[0], in_ready[0]);
      end
    end
  endtask
  task automatic test_chunk16;
    logic [15:0] rs; logic rc, ro; int lat;
    run_op(1, 16'hABCD, 16'h1111, 1'b0, rs, rc, ro, lat);
    tests++;
    if ({rs, rc, ro} !== {16'hBCDE, 1'b0, 1'b0} || lat !== 1) begin
      fails++;
      $display("FAIL chunk16_add: got sum=%h c=%b ov=%b lat=%0d, want sum=bcde c=0 ov=0 lat=1", rs, rc, ro, lat);
    end
    consume(1);
  endtask
  task automatic test_backpressure;
    logic [15:0] rs; logic rc, ro; int lat;
    out_ready[0] = 1'b0;
    run_op(0, 16'h1234, 16'h0FFF, 1'b0, rs, rc, ro, lat);
    tests++;
    if (rs !== 16'h2233 || lat !== 4) begin
      fails++;
      $display("FAIL bp_result: got sum=%h lat=%0d want 2233 lat=4", rs, lat);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid[0] = 1'b1; a[0] = 16'($urandom); b[0] = 16'($urandom); sub[0] = 1'($urandom);
      tick();
      tests++;
      if ({out_valid[0], in_ready[0], sum[0], c_out[0], overflow[0]} !== {2'b10, 16'h2233, 2'b00}) begin
        fails++;
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b sum=%h c=%b ov=%b, want 1 0 2233 0 0",
                 i, out_valid[0], in_ready[0], sum[0], c_out[0], overflow[0]);
      end
    end
    consume(0);
    tests++;
    if ({out_valid[0], in_ready[0]} !== 2'b01) begin
      fails++;
      $display("FAIL bp_release: got vld=%b rdy=%b want 0 1 (no accept on handoff edge)", out_valid[0], in_ready[0]);
    end
    in_valid[0] = 1'b0;
  endtask
  task automatic test_reset_mid_run;
    logic [15:0] rs; logic rc, ro; int lat;
    a[0] = 16'h1111; b[0] = 16'h1111; sub[0] = 1'b0; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready[0], out_valid[0], sum[0], c_out[0], overflow[0]} !== 20'h0) begin
      fails++;
      $display("FAIL abort_outputs: got rdy=%b vld=%b sum=%h c=%b ov=%b, want all 0",
               in_ready[0], out_valid[0], sum[0], c_out[0], overflow[0]);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (out_valid[0] !== 1'b0) begin fails++; $display("FAIL abort_no_result: got vld=%b want 0", out_valid[0]); end
    run_op(0, 16'h0001, 16'h0001, 1'b0, rs, rc, ro, lat);
    tests++;
    if ({rs, rc, ro} !== {16'h0002, 2'b00} || lat !== 4) begin
      fails++;
      $display("FAIL abort_recover: got sum=%h c=%b ov=%b lat=%0d want 0002 0 0 lat=4", rs, rc, ro, lat);
    end
    consume(0);
  endtask
  task automatic test_random;
    logic [15:0] x, y, rs; logic s, rc, ro; logic [17:0] e; int lat, h;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1000; i++) begin
        x = 16'($urandom); y = 16'($urandom); s = 1'($urandom);
        h = $urandom_range(0, 2);
        out_ready[k] = h == 0;
        e = model(x, y, s);
        run_op(k, x, y, s, rs, rc, ro, lat);
        tests++;
        if ({ro, rc, rs} !== e || lat !== nlat[k]) begin
          fails++;
          $display("FAIL rand_cfg%0d_%0d: %h %s %h got ov=%b c=%b sum=%h lat=%0d want ov=%b c=%b sum=%h lat=%0d",
                   k, i, x, s ? "-" : "+", y, ro, rc, rs, lat, e[17], e[16], e[15:0], nlat[k]);
        end
        repeat (h) tick();
        tests++;
        if ({overflow[k], c_out[k], sum[k], out_valid[k]} !== {e, 1'b1}) begin
          fails++;
          $display("FAIL rand_hold_cfg%0d_%0d: got ov=%b c=%b sum=%h vld=%b want ov=%b c=%b sum=%h vld=1",
                   k, i, overflow[k], c_out[k], sum[k], out_valid[k], e[17], e[16], e[15:0]);
        end
        consume(k);
      end
    end
  endtask
  initial begin
    a = '{16'h0, 16'h0};
    b = '{16'h0, 16'h0};
    test_reset();
    test_directed();
    test_chunk16();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
